fifo_window_ctrl: RTL and testbench



---
 rtl/fifo_window_ctrl_pkg.sv | 28 ++
 rtl/fifo_window_ctrl_if.sv | 35 +++
 rtl/fifo_window_ctrl_win_pos_counter.sv | 74 +++++++
 rtl/fifo_window_ctrl.sv | 128 ++++++++++++
 tb/tb_fifo_window_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_window_ctrl_pkg.sv
// Shared types and constants for the sliding-window FIFO sequencer.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned IFM_SIZE_DEF    = 9;
    localparam int unsigned KERNAL_SIZE_DEF = 5;
    localparam int unsigned STRIDE_DEF      = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) res++;
        return res;
    endfunction

    function automatic int unsigned ofm_size(input int unsigned ifm, input int unsigned k,
                                             input int unsigned s);
        return (ifm - k) / s + 1;
    endfunction

    localparam int unsigned OFM_SIZE = ofm_size(IFM_SIZE_DEF, KERNAL_SIZE_DEF, STRIDE_DEF);

endpackage

// File: rtl/fifo_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle of the window sequencer.
// FIFO_WINDOW_CTRL_BACKPRESSURE_EN adds the out_ready consumer handshake.
interface fifo_window_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 fifo_enable;
    logic                 window_valid;
    logic [CNT_WIDTH-1:0] ofm_row;
    logic [CNT_WIDTH-1:0] ofm_col;
    logic                 busy;
    logic                 frame_done;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
    logic                 out_ready;
`endif

    modport master (
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
        input  out_ready,
`endif
        input  start, in_valid,
        output in_ready, fifo_enable, window_valid, ofm_row, ofm_col, busy, frame_done
    );

    modport slave (
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
        output out_ready,
`endif
        output start, in_valid,
        input  in_ready, fifo_enable, window_valid, ofm_row, ofm_col, busy, frame_done
    );

endinterface

// File: rtl/fifo_window_ctrl_win_pos_counter.sv
// Raster pixel row/col counter with stride phase tracking; flags an in-bounds, aligned window.
module win_pos_counter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned IFM_SIZE    = IFM_SIZE_DEF,
    parameter int unsigned KERNAL_SIZE = KERNAL_SIZE_DEF,
    parameter int unsigned STRIDE      = STRIDE_DEF,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic accept_i,
    output logic hit_o,
    output logic last_o,
    output logic row_end_o
);
    localparam int unsigned PhW = clog2(STRIDE + 1);

    logic [CNT_WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [PhW-1:0]       col_ph_q, col_ph_d, row_ph_q, row_ph_d;

    // Phase is 0 at the first full-window coordinate and every STRIDE after it.
    function automatic logic [PhW-1:0] ph_next(input logic [PhW-1:0] ph,
                                               input logic [CNT_WIDTH-1:0] coord);
        if (coord == CNT_WIDTH'(KERNAL_SIZE - 1)) return '0;
        if (ph == PhW'(STRIDE - 1)) return '0;
        return ph + 1'b1;
    endfunction

    assign row_end_o = (col_q == CNT_WIDTH'(IFM_SIZE - 1));
    assign last_o    = row_end_o & (row_q == CNT_WIDTH'(IFM_SIZE - 1));
    assign hit_o     = (row_q >= CNT_WIDTH'(KERNAL_SIZE - 1)) &
                       (col_q >= CNT_WIDTH'(KERNAL_SIZE - 1)) &
                       (row_ph_q == '0) & (col_ph_q == '0);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (clear_i) begin
            col_d    = '0;
            row_d    = '0;
            col_ph_d = '0;
            row_ph_d = '0;
        end else if (accept_i) begin
            if (row_end_o) begin
                col_d    = '0;
                col_ph_d = '0;
                row_d    = row_q + 1'b1;
                row_ph_d = ph_next(row_ph_q, row_q + 1'b1);
            end else begin
                col_d    = col_q + 1'b1;
                col_ph_d = ph_next(col_ph_q, col_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            col_ph_q <= col_ph_d;
            row_ph_q <= row_ph_d;
        end
    end

endmodule

// File: rtl/fifo_window_ctrl.sv
// Sequencer for the sliding-window FIFO: accepts raster pixels, drives fifo_enable, flags windows.
// FIFO_WINDOW_CTRL_BACKPRESSURE_EN holds each window until out_ready and stalls the stream.
module fifo_window_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned IFM_SIZE    = IFM_SIZE_DEF,
    parameter int unsigned KERNAL_SIZE = KERNAL_SIZE_DEF,
    parameter int unsigned STRIDE      = STRIDE_DEF,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input logic                clk,
    input logic                reset,
    fifo_window_ctrl_if.master bus
);
    if (CNT_WIDTH < clog2(IFM_SIZE + 1)) begin : g_bad_cnt_width
        $error("CNT_WIDTH too narrow for IFM_SIZE");
    end

    state_e               state_q, state_d;
    logic                 in_ready, accept, start_frame, hit, last, row_end;
    logic                 wv_q, wv_d, fd_q, fd_d;
    logic [CNT_WIDTH-1:0] ofm_row_q, ofm_row_d, ofm_col_q, ofm_col_d;
    logic [CNT_WIDTH-1:0] win_row_q, win_row_d, win_col_q, win_col_d;

`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
    logic last_q, last_d, hold;
    assign hold     = wv_q & ~bus.out_ready;
    // last_q: final pixel taken, waiting only for its window to drain.
    assign in_ready = (state_q == StRun) & ~hold & ~last_q;
`else
    assign in_ready = (state_q == StRun);
`endif

    assign start_frame = (state_q == StIdle) & bus.start;
    assign accept      = bus.in_valid & in_ready;

    win_pos_counter #(
        .IFM_SIZE   (IFM_SIZE),
        .KERNAL_SIZE(KERNAL_SIZE),
        .STRIDE     (STRIDE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pos (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (start_frame),
        .accept_i (accept),
        .hit_o    (hit),
        .last_o   (last),
        .row_end_o(row_end)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StRun;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
            StRun:  if ((accept & last & ~hit) | (last_q & wv_q & bus.out_ready)) state_d = StDone;
`else
            StRun:  if (accept & last) state_d = StDone;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wv_d      = accept & hit;
        ofm_row_d = ofm_row_q;
        ofm_col_d = ofm_col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (accept & hit) begin
            ofm_row_d = win_row_q;
            ofm_col_d = win_col_q;
            win_col_d = win_col_q + 1'b1;
        end
        if (start_frame) begin
            win_row_d = '0;
            win_col_d = '0;
        end else if (accept & row_end) begin
            win_col_d = '0;
            // Only pixel rows that produced windows advance the output row.
            if (hit || win_col_q != '0) win_row_d = win_row_q + 1'b1;
        end
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
        if (hold) wv_d = 1'b1;
        last_d = last_q;
        if (start_frame || state_q == StDone) last_d = 1'b0;
        else if (accept & last & hit) last_d = 1'b1;
`endif
        fd_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wv_q      <= 1'b0;
            fd_q      <= 1'b0;
            ofm_row_q <= '0;
            ofm_col_q <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wv_q      <= wv_d;
            fd_q      <= fd_d;
            ofm_row_q <= ofm_row_d;
            ofm_col_q <= ofm_col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.fifo_enable  = accept;
    assign bus.window_valid = wv_q;
    assign bus.ofm_row      = ofm_row_q;
    assign bus.ofm_col      = ofm_col_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.frame_done   = fd_q;

endmodule

// File: tb/tb_fifo_window_ctrl.sv
// Bench for fifo_window_ctrl: STRIDE=1 and STRIDE=2 instances share one pixel stream.
module tb_fifo_window_ctrl;

    typedef struct {
        logic [7:0] r;
        logic [7:0] c;
        int         idx;
    } win_t;

    typedef struct {
        bit rst, st, iv;
        bit rdy, fe, busy, wv, fd;
    } vec_t;

    localparam int Limit = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;

    always #5 clk = ~clk;

    fifo_window_ctrl_if #(.CNT_WIDTH(8)) ifc1 ();
    fifo_window_ctrl_if #(.CNT_WIDTH(8)) ifc2 ();

    assign ifc1.start    = start;
    assign ifc1.in_valid = in_valid;
    assign ifc2.start    = start;
    assign ifc2.in_valid = in_valid;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
    assign ifc1.out_ready = out_ready;
    assign ifc2.out_ready = 1'b1;
`endif

    fifo_window_ctrl #(.IFM_SIZE(9), .KERNAL_SIZE(5), .STRIDE(1), .CNT_WIDTH(8)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc1)
    );

    fifo_window_ctrl #(.IFM_SIZE(9), .KERNAL_SIZE(5), .STRIDE(2), .CNT_WIDTH(8)) dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc2)
    );

    int   checks = 0;
    int   errors = 0;
    win_t q0[$];
    win_t q1[$];
    int   acc[2];
    int   fd_cnt[2];
    int   popped[2];
    int   exp_n[2];
    bit   prev_fe[2];
    bit   prev_wv[2];
    bit   prev_or[2];
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frame_begin();
        win_t e;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; fd_cnt[i] = 0; popped[i] = 0;
            prev_fe[i] = 0; prev_wv[i] = 0; prev_or[i] = 1;
        end
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                e.idx = r * 9 + c + 1;
                if (r >= 4 && c >= 4) begin
                    e.r = 8'(r - 4);
                    e.c = 8'(c - 4);
                    q0.push_back(e);
                    if ((r - 4) % 2 == 0 && (c - 4) % 2 == 0) begin
                        e.r = 8'((r - 4) / 2);
                        e.c = 8'((c - 4) / 2);
                        q1.push_back(e);
                    end
                end
            end
        end
        exp_n[0] = q0.size();
        exp_n[1] = q1.size();
    endtask

    task automatic mon(input int id, input logic fe, input logic wv, input logic fd,
                       input logic orr, input logic [7:0] orow, input logic [7:0] ocol);
        win_t e;
        int   qs;
        qs = (id == 0) ? q0.size() : q1.size();
        if (wv) chk($sformatf("wv_source_dut%0d", id),
                    32'(prev_fe[id] || (prev_wv[id] && !prev_or[id])), 1);
        if (wv && orr) begin
            if (qs == 0) begin
                chk($sformatf("extra_window_dut%0d", id), popped[id] + 1, exp_n[id]);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("ofm_row_dut%0d_w%0d", id, popped[id]), 32'(orow), 32'(e.r));
                chk($sformatf("ofm_col_dut%0d_w%0d", id, popped[id]), 32'(ocol), 32'(e.c));
                chk($sformatf("win_accept_idx_dut%0d_w%0d", id, popped[id]), acc[id], e.idx);
                popped[id]++;
            end
        end
        if (fd) begin
            fd_cnt[id]++;
            chk($sformatf("done_accepts_dut%0d", id), acc[id], 81);
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
            chk($sformatf("done_after_drain_dut%0d", id), qs, 0);
`else
            chk($sformatf("done_latency_dut%0d", id), 32'(prev_fe[id]), 1);
`endif
        end
        prev_fe[id] = fe;
        prev_wv[id] = wv;
        prev_or[id] = orr;
        if (fe) acc[id]++;
    endtask

    always @(negedge clk) begin
        mon(0, ifc1.fifo_enable, ifc1.window_valid, ifc1.frame_done, out_ready,
            ifc1.ofm_row, ifc1.ofm_col);
        mon(1, ifc2.fifo_enable, ifc2.window_valid, ifc2.frame_done, 1'b1,
            ifc2.ofm_row, ifc2.ofm_col);
    end

    task automatic frame_end(input bit in_time);
        chk("frame_in_time", 32'(in_time), 1);
        chk("win_count_s1", popped[0], 25);
        chk("win_count_s2", popped[1], 9);
        chk("accepts_s1", acc[0], 81);
        chk("accepts_s2", acc[1], 81);
        chk("done_pulses_s1", fd_cnt[0], 1);
        chk("done_pulses_s2", fd_cnt[1], 1);
        chk("busy_end_s1", 32'(ifc1.busy), 0);
        chk("busy_end_s2", 32'(ifc2.busy), 0);
    endtask

`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
    bit bp_mode = 0;
`endif

    task automatic run_frame(input bit gaps, input bit mid_start);
        int cyc;
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
        bit held;
        held = 0;
`endif
        cyc = 0;
        frame_begin();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(fd_cnt[0] != 0 && fd_cnt[1] != 0 && !ifc1.busy && !ifc2.busy) && cyc < Limit)
        begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = mid_start && (cyc == 60);
`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
            if (bp_mode && !held && ifc1.window_valid && ifc1.ofm_row == 8'd2 &&
                ifc1.ofm_col == 8'd3) begin
                held = 1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk($sformatf("hold_wv_%0d", k), 32'(ifc1.window_valid), 1);
                    chk($sformatf("hold_row_%0d", k), 32'(ifc1.ofm_row), 2);
                    chk($sformatf("hold_col_%0d", k), 32'(ifc1.ofm_col), 3);
                    chk($sformatf("hold_in_ready_%0d", k), 32'(ifc1.in_ready), 0);
                    chk($sformatf("hold_fifo_en_%0d", k), 32'(ifc1.fifo_enable), 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
`endif
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        frame_end(cyc < Limit);
    endtask

    initial begin
        int n;
        tbl[0] = '{rst: 1, st: 0, iv: 0, rdy: 0, fe: 0, busy: 0, wv: 0, fd: 0};
        tbl[1] = '{rst: 0, st: 0, iv: 1, rdy: 0, fe: 0, busy: 0, wv: 0, fd: 0};
        tbl[2] = '{rst: 0, st: 1, iv: 0, rdy: 1, fe: 0, busy: 1, wv: 0, fd: 0};
        tbl[3] = '{rst: 0, st: 0, iv: 1, rdy: 1, fe: 1, busy: 1, wv: 0, fd: 0};
        tbl[4] = '{rst: 0, st: 1, iv: 1, rdy: 1, fe: 1, busy: 1, wv: 0, fd: 0};
        tbl[5] = '{rst: 0, st: 0, iv: 0, rdy: 1, fe: 0, busy: 1, wv: 0, fd: 0};
        tbl[6] = '{rst: 1, st: 0, iv: 1, rdy: 0, fe: 0, busy: 0, wv: 0, fd: 0};
        tbl[7] = '{rst: 0, st: 0, iv: 0, rdy: 0, fe: 0, busy: 0, wv: 0, fd: 0};

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; in_valid = tbl[i].iv;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(ifc1.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_fifo_en", i), 32'(ifc1.fifo_enable), 32'(tbl[i].fe));
            chk($sformatf("vec%0d_busy", i), 32'(ifc1.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_wv", i), 32'(ifc1.window_valid), 32'(tbl[i].wv));
            chk($sformatf("vec%0d_done", i), 32'(ifc1.frame_done), 32'(tbl[i].fd));
        end
        start = 1'b0; in_valid = 1'b0;

        // Continuous stream.
        run_frame(0, 0);
        // ~50% duty gaps with a start pulse mid-frame.
        run_frame(1, 1);

        // Reset at the 30th accept, then a fresh frame.
        frame_begin();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (acc[0] != 30 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_30_accepts", acc[0], 30);
        reset = 1'b1;
        #1;
        chk("rst_in_ready_s1", 32'(ifc1.in_ready), 0);
        chk("rst_fifo_en_s1", 32'(ifc1.fifo_enable), 0);
        chk("rst_wv_s1", 32'(ifc1.window_valid), 0);
        chk("rst_ofm_row_s1", 32'(ifc1.ofm_row), 0);
        chk("rst_ofm_col_s1", 32'(ifc1.ofm_col), 0);
        chk("rst_busy_s1", 32'(ifc1.busy), 0);
        chk("rst_done_s1", 32'(ifc1.frame_done), 0);
        chk("rst_in_ready_s2", 32'(ifc2.in_ready), 0);
        chk("rst_fifo_en_s2", 32'(ifc2.fifo_enable), 0);
        chk("rst_busy_s2", 32'(ifc2.busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 0);

`ifdef FIFO_WINDOW_CTRL_BACKPRESSURE_EN
        bp_mode = 1;
        run_frame(0, 0);
        bp_mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
